// File: rtl/alu_sequencer.sv
// Multi-cycle 8-bit ALU sequencer: IDLE/EXEC/DONE handshake, shift-add MUL, restoring DIV.
// Optional divider enabled by defining ALU_SEQ_DIV_EN; otherwise DIV reports an error in one cycle.
module alu_sequencer #(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_cin,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_s,
  output logic       rsp_cout,
  output logic       rsp_zero,
  output logic       rsp_error,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_AND = 3'b101, OP_OR  = 3'b110, OP_XOR = 3'b111;
  localparam logic [3:0] EXEC_LAST = 4'(8 / ITER_PER_CYCLE - 1);

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [7:0]  a_reg, b_reg;
  logic        cin_reg;
  logic [3:0]  cnt_reg;
  logic [15:0] acc_reg, acc_next;   // MUL product accumulator / DIV partial remainder
  logic [15:0] mc_reg, mc_next;     // shifted multiplicand
  logic [7:0]  q_reg, q_next;       // MUL multiplier / DIV dividend-then-quotient
  logic        accept, multi_cmd;
  logic [7:0]  res_s;
  logic        res_cout, res_err;
  logic [8:0]  diff;

  assign cmd_ready = rst_n && (state_reg == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = (state_reg == DONE);

`ifdef ALU_SEQ_DIV_EN
  assign multi_cmd = (cmd_op == OP_MUL) || (cmd_op == OP_DIV);
`else
  assign multi_cmd = (cmd_op == OP_MUL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = multi_cmd ? EXEC : DONE;
      EXEC: if (cnt_reg == 4'd0) state_next = DONE;
      DONE: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One or two MUL/DIV iterations per clock, unrolled combinationally.
  always_comb begin
    acc_next = acc_reg;
    mc_next  = mc_reg;
    q_next   = q_reg;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      if (op_reg == OP_MUL) begin
        if (q_next[0]) acc_next = acc_next + mc_next;
        mc_next = {mc_next[14:0], 1'b0};
        q_next  = {1'b0, q_next[7:1]};
      end
`ifdef ALU_SEQ_DIV_EN
      else begin
        acc_next[8:0] = {acc_next[7:0], q_next[7]};
        q_next        = {q_next[6:0], 1'b0};
        if (acc_next[8:0] >= {1'b0, b_reg}) begin
          acc_next[8:0] = acc_next[8:0] - {1'b0, b_reg};
          q_next[0]     = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg  <= OP_NOP;
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      cin_reg <= 1'b0;
      cnt_reg <= 4'd0;
      acc_reg <= 16'h0000;
      mc_reg  <= 16'h0000;
      q_reg   <= 8'h00;
    end else if (accept) begin
      op_reg  <= cmd_op;
      a_reg   <= cmd_a;
      b_reg   <= cmd_b;
      cin_reg <= cmd_cin;
      cnt_reg <= EXEC_LAST;
      acc_reg <= 16'h0000;
      mc_reg  <= {8'h00, cmd_a};
      q_reg   <= (cmd_op == OP_MUL) ? cmd_b : cmd_a;
    end else if (state_reg == EXEC) begin
      acc_reg <= acc_next;
      mc_reg  <= mc_next;
      q_reg   <= q_next;
      if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
    end
  end

  // Results derive from registers that are frozen outside acceptance/EXEC, so DONE outputs stay stable.
  always_comb begin
    res_s    = 8'h00;
    res_cout = 1'b0;
    res_err  = 1'b0;
    diff     = 9'h000;
    case (op_reg)
      OP_ADD: {res_cout, res_s} = {1'b0, a_reg} + {1'b0, b_reg} + 9'(cin_reg);
      OP_SUB: begin
        diff     = {1'b0, a_reg} - {1'b0, b_reg} - 9'(cin_reg);
        res_s    = diff[7:0];
        res_cout = diff[8];
      end
      OP_MUL: begin
        res_s   = acc_reg[7:0];
        res_err = |acc_reg[15:8];
      end
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        res_s   = (b_reg == 8'h00) ? 8'hFF : q_reg;
        res_err = (b_reg == 8'h00);
      end
`else
      OP_DIV: res_err = 1'b1;
`endif
      OP_AND: res_s = a_reg & b_reg;
      OP_OR:  res_s = a_reg | b_reg;
      OP_XOR: res_s = a_reg ^ b_reg;
      default: res_s = 8'h00;
    endcase
  end

  assign rsp_s     = rsp_valid ? res_s : 8'h00;
  assign rsp_cout  = rsp_valid && res_cout;
  assign rsp_error = rsp_valid && res_err;
  assign rsp_zero  = rsp_valid && (res_s == 8'h00);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; DIV expectations follow ALU_SEQ_DIV_EN.
module tb_alu_sequencer;
  localparam int ITER = 1;
  localparam int MUL_LAT = 1 + 8 / ITER;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [7:0] cmd_a = 8'h00, cmd_b = 8'h00;
  logic       cmd_cin = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_s;
  logic       rsp_cout, rsp_zero, rsp_error, busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_sequencer #(.ITER_PER_CYCLE(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_cout(rsp_cout),
    .rsp_zero(rsp_zero), .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer a command for one edge, then scramble inputs to prove they were registered.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    check("cmd_ready_before", {15'd0, cmd_ready}, 16'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = ~op; cmd_a = ~a; cmd_b = ~b; cmd_cin = ~cin;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat <= 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("busy_after_hs", {15'd0, busy}, 16'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] es, input logic ec, input logic ez,
                        input logic ee, input int elat);
    int lat;
    send(op, a, b, cin);
    wait_rsp(lat);
    check({tag, "_lat"}, 16'(lat), 16'(elat));
    check({tag, "_s"}, {8'd0, rsp_s}, {8'd0, es});
    check({tag, "_cout"}, {15'd0, rsp_cout}, {15'd0, ec});
    check({tag, "_zero"}, {15'd0, rsp_zero}, {15'd0, ez});
    check({tag, "_err"}, {15'd0, rsp_error}, {15'd0, ee});
    $display("op %s a=%h b=%h cin=%0d -> s=%h cout=%0d zero=%0d err=%0d lat=%0d",
             tag, a, b, cin, rsp_s, rsp_cout, rsp_zero, rsp_error, lat);
    handshake();
  endtask

  initial begin
    int lat;
    int seen;
    #2;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_valid", {15'd0, rsp_valid}, 16'd0);
    check("rst_ready", {15'd0, cmd_ready}, 16'd0);
    check("rst_s", {8'd0, rsp_s}, 16'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {15'd0, cmd_ready}, 16'd1);

    run_op("add",      3'b001, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1);
    run_op("add_wrap", 3'b001, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1);
    run_op("sub_eq",   3'b010, 8'h05, 8'h05, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    run_op("sub_brw",  3'b010, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1);
    run_op("and",      3'b101, 8'hA5, 8'h3C, 1'b1, 8'h24, 1'b0, 1'b0, 1'b0, 1);
    run_op("or",       3'b110, 8'hA5, 8'h3C, 1'b0, 8'hBD, 1'b0, 1'b0, 1'b0, 1);
    run_op("xor",      3'b111, 8'hA5, 8'h3C, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1);
    run_op("nop",      3'b000, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    run_op("mul",      3'b011, 8'h0C, 8'h0B, 1'b1, 8'h84, 1'b0, 1'b0, 1'b0, MUL_LAT);
    run_op("mul_ovf",  3'b011, 8'h20, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, MUL_LAT);
    run_op("mul_max",  3'b011, 8'hFF, 8'hFF, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, MUL_LAT);
`ifdef ALU_SEQ_DIV_EN
    run_op("div",      3'b100, 8'hC8, 8'h07, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b0, MUL_LAT);
    run_op("div_zero", 3'b100, 8'h37, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, MUL_LAT);
`else
    run_op("div_off",  3'b100, 8'hC8, 8'h07, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1);
`endif

    // Backpressure with a competing command held on the input.
    send(3'b001, 8'h01, 8'h02, 1'b0);
    wait_rsp(lat);
    check("bp_lat", 16'(lat), 16'd1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b111; cmd_a = 8'hF0; cmd_b = 8'h0F; cmd_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {15'd0, rsp_valid}, 16'd1);
      check("bp_s", {8'd0, rsp_s}, 16'h0003);
      check("bp_ready", {15'd0, cmd_ready}, 16'd0);
    end
    $display("backpressure held 5 cycles: s=%h", rsp_s);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_hs_valid", {15'd0, rsp_valid}, 16'd0);
    check("bp_hs_ready", {15'd0, cmd_ready}, 16'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp_next_valid", {15'd0, rsp_valid}, 16'd1);
    check("bp_next_s", {8'd0, rsp_s}, 16'h00FF);
    $display("post-handshake command accepted: s=%h", rsp_s);
    handshake();

    // Reset in the middle of a MUL.
    send(3'b011, 8'h03, 8'h03, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check("mid_busy", {15'd0, busy}, 16'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {15'd0, busy}, 16'd0);
    check("arst_valid", {15'd0, rsp_valid}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen++;
    end
    check("arst_no_rsp", 16'(seen), 16'd0);
    $display("reset mid-EXEC: spurious activity cycles=%0d", seen);
    run_op("after_rst", 3'b001, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter ITER_PER_CYCLE, 1, multiply/divide iterations per clock; legal values 1 or 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-006 cmd_op  input  3  000 NOP, 001 ADD, 010 SUB, 011 MUL, 100 DIV, 101 AND, 110 OR, 111 XOR.
REQ-007 cmd_a, cmd_b  input  8 each  operands.
REQ-008 cmd_cin  input  1  carry/borrow in; used by ADD and SUB only.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes the result.
REQ-011 rsp_s  output  8  result byte.
REQ-012 rsp_cout, rsp_zero, rsp_error  output  1 each  carry/borrow out, result-is-zero, error.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States IDLE, EXEC, DONE shall be implemented; cmd_ready shall equal (state==IDLE).
REQ-015 A command shall be accepted when cmd_valid and cmd_ready are both high at a rising edge; op, operands and cin shall be registered at that edge, and later input changes shall be ignored.
REQ-016 NOP/ADD/SUB/AND/OR/XOR shall go IDLE->DONE, with rsp_valid high in the first cycle after the acceptance edge.
REQ-017 MUL/DIV shall go IDLE->EXEC, remain in EXEC for exactly 8/ITER_PER_CYCLE cycles, then enter DONE.
REQ-018 ADD: {rsp_cout,rsp_s} = A+B+cin, 9-bit.
REQ-019 SUB: rsp_s = (A-B-cin) mod 256; rsp_cout = 1 iff A < B+cin.
REQ-020 MUL: unsigned shift-add over 8 iterations; rsp_s = product[7:0]; rsp_error = 1 iff product[15:8] != 0.
REQ-021 DIV: unsigned restoring division over 8 iterations; rsp_s = quotient.
REQ-022 DIV by B=0: EXEC timing shall be unchanged, rsp_s = 8'hFF, and rsp_error = 1.
REQ-023 AND/OR/XOR shall be bitwise; NOP shall give rsp_s = 0.
REQ-024 rsp_cout shall be 0 for all ops except ADD/SUB; rsp_error shall be 0 except under REQ-020/022/030.
REQ-025 rsp_zero shall equal (rsp_s == 0) in DONE, including NOP.
REQ-026 In DONE, rsp_valid and all rsp_* shall hold stable until rsp_ready is sampled high; that edge shall return the state to IDLE.
REQ-027 A new command shall not be accepted in the same cycle as the response handshake; the earliest acceptance is the following cycle.
REQ-028 rsp_ready while rsp_valid is low shall have no effect; cmd_valid while busy shall be ignored (no queueing).

Reset
REQ-029 rst_n low shall immediately force the state to IDLE, clear all operand and iteration registers, and drive rsp_valid=0, rsp_s=0, rsp_cout=0, rsp_zero=0, rsp_error=0, busy=0 and cmd_ready=0. cmd_ready shall be 1 from the first clock after rst_n deasserts. Reset during EXEC or DONE shall discard the operation with no response.

Configuration
REQ-030 Macro ALU_SEQ_DIV_EN: when defined, DIV shall be implemented per REQ-021/022. When undefined, no divider logic shall exist and DIV shall behave as a single-cycle op (IDLE->DONE) with rsp_s=0, rsp_zero=1 and rsp_error=1.

Verification
REQ-031 ADD A=8'hF0, B=8'h20, cin=1 -> one cycle later: rsp_s=8'h11, rsp_cout=1, rsp_zero=0, rsp_error=0.
REQ-032 SUB A=8'h05, B=8'h05, cin=0 -> rsp_s=0, rsp_zero=1, rsp_cout=0; repeat with cin=1 -> rsp_s=8'hFF, rsp_cout=1.
REQ-033 MUL 8'h0C x 8'h0B, ITER_PER_CYCLE=1 -> rsp_valid after 9 cycles, rsp_s=8'h84, rsp_error=0; MUL 8'h20 x 8'h10 -> rsp_s=0, rsp_error=1, rsp_zero=1.
REQ-034 DIV 8'hC8 / 8'h07 -> rsp_s=8'h1C; DIV by 0 -> rsp_s=8'hFF, rsp_error=1. Without ALU_SEQ_DIV_EN -> single cycle, rsp_s=0, rsp_error=1.
REQ-035 Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 and a new op -> outputs stable, no acceptance; release -> new command accepted exactly one cycle after the handshake.
REQ-036 Assert rst_n=0 mid-EXEC of a MUL -> busy=0 and rsp_valid=0 with no clock edge, and no response is produced after reset is released.
